// File: rtl/reg_scoreboard.sv
// Register scoreboard: one saturating-free outstanding-write counter per GPR
// (r1..r31). Sources with a pending write report busy; issue stalls on a busy
// operand, on a saturated destination counter, or during flush.
//
// Handshake: an instruction transfers on a rising edge where issue_valid and
// issue_ready are both high. issue_ready is a pure function of the presented
// operands, writeback and flush and never depends on issue_valid, so decode
// may look at it before committing to present the instruction.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic       issue_we,
  input  logic [4:0] issue_wa,
  input  logic [4:0] issue_ra1,
  input  logic [4:0] issue_ra2,
  input  logic       issue_use1,
  input  logic       issue_use2,
  input  logic       wb_valid,
  input  logic [4:0] wb_wa,
  input  logic       flush,
  output logic       busy1,
  output logic       busy2,
  output logic [6:0] pending_total
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q   [1:31];
  logic [CNT_W-1:0] cnt_d   [1:31];
  logic [CNT_W-1:0] cnt_eff [0:31];
  logic [6:0]       pending_total_q;
  logic [6:0]       pending_total_d;
  logic             accept;
  logic             wb_dec;
  logic             issue_inc;
  logic             wb_underflow;

  // Effective count seen by this cycle's issue: a same-cycle writeback
  // already releases its register (regfile is write-through). Entry 0 is a
  // constant zero so r0 can never look busy. A writeback to an idle
  // register is ignored rather than wrapping.
  always_comb begin
    wb_dec       = wb_valid & (wb_wa != 5'd0);
    wb_underflow = 1'b0;
    cnt_eff[0]   = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_eff[i] = cnt_q[i];
      if (wb_dec && (wb_wa == 5'(i))) begin
        if (cnt_q[i] != '0) cnt_eff[i] = cnt_q[i] - CNT_ONE;
        else                wb_underflow = !flush;
      end
    end
  end

  assign busy1 = (issue_ra1 != 5'd0) & (cnt_eff[issue_ra1] != '0);
  assign busy2 = (issue_ra2 != 5'd0) & (cnt_eff[issue_ra2] != '0);

  // Busy is evaluated before this instruction's own increment, so an
  // instruction reading and writing the same register does not block itself.
  assign issue_ready = !flush
                     & !(issue_use1 & busy1)
                     & !(issue_use2 & busy2)
                     & !(issue_we & (issue_wa != 5'd0) & (cnt_eff[issue_wa] == CNT_MAX));

  assign accept    = issue_valid & issue_ready;
  assign issue_inc = accept & issue_we & (issue_wa != 5'd0);

  // Next counter values and their sum; flush wipes every counter and
  // ignores the cycle's issue and writeback.
  always_comb begin
    pending_total_d = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else begin
        if (issue_inc && (issue_wa == 5'(i))) cnt_d[i] = cnt_d[i] + CNT_ONE;
        if (wb_dec && (wb_wa == 5'(i)) && (cnt_q[i] != '0)) cnt_d[i] = cnt_d[i] - CNT_ONE;
      end
      pending_total_d = pending_total_d + 7'(cnt_d[i]);
    end
  end

  // Counter and total registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
      pending_total_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
      pending_total_q <= pending_total_d;
    end
  end

  assign pending_total = pending_total_q;

  // A writeback to a register with nothing outstanding indicates a pipeline bug.
  a_no_underflow : assert property (@(posedge clk) disable iff (!resetn) !wb_underflow);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus a randomized run, all
// checked against an integer-array model of outstanding writes per register.
module tb_reg_scoreboard;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  // Clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic       issue_valid, issue_ready, issue_we, issue_use1, issue_use2;
  logic [4:0] issue_wa, issue_ra1, issue_ra2, wb_wa;
  logic       wb_valid, flush, busy1, busy2;
  logic [6:0] pending_total;

  int total = 0;
  int bad   = 0;
  int cnt_m [32];
  logic [6:0] exp_q [$];

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_we(issue_we), .issue_wa(issue_wa),
    .issue_ra1(issue_ra1), .issue_ra2(issue_ra2),
    .issue_use1(issue_use1), .issue_use2(issue_use2),
    .wb_valid(wb_valid), .wb_wa(wb_wa), .flush(flush),
    .busy1(busy1), .busy2(busy2), .pending_total(pending_total)
  );

  // Reference model: count of writes still outstanding per register.
  function automatic int m_eff(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (wb_valid && wb_wa == r && cnt_m[r] > 0) return cnt_m[r] - 1;
    return cnt_m[r];
  endfunction

  function automatic logic m_busy(input logic [4:0] r);
    return (r != 5'd0) && (m_eff(r) > 0);
  endfunction

  function automatic logic m_ready();
    if (flush) return 1'b0;
    if (issue_use1 && m_busy(issue_ra1)) return 1'b0;
    if (issue_use2 && m_busy(issue_ra2)) return 1'b0;
    if (issue_we && issue_wa != 5'd0 && m_eff(issue_wa) == MAXC) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_total();
    int s = 0;
    for (int i = 0; i < 32; i++) s += cnt_m[i];
    return s;
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic we, input logic [4:0] wa,
                       input logic [4:0] ra1, input logic u1,
                       input logic [4:0] ra2, input logic u2,
                       input logic wbv, input logic [4:0] wbwa, input logic fl);
    issue_valid = v;  issue_we = we;  issue_wa = wa;
    issue_ra1 = ra1;  issue_use1 = u1;
    issue_ra2 = ra2;  issue_use2 = u2;
    wb_valid = wbv;   wb_wa = wbwa;   flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock and update the model with what the edge should commit.
  task automatic step();
    logic acc;
    int   dr;
    acc = issue_valid && m_ready();
    dr  = (wb_valid && wb_wa != 5'd0 && cnt_m[wb_wa] > 0) ? int'(wb_wa) : 0;
    @(posedge clk);
    if (!resetn || flush) begin
      for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    end else begin
      if (acc && issue_we && issue_wa != 5'd0) cnt_m[issue_wa]++;
      if (dr != 0) cnt_m[dr]--;
    end
    #1;
  endtask

  task automatic issue_to(input logic [4:0] wa);
    drive(1, 1, wa, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 5'd8, 1, 5'd9, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    step(); step();
    total++; if (pending_total !== 7'd0) begin bad++; $display("FAIL reset_total: got %0d expected 0", pending_total); end
    total++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b%b expected 00", busy1, busy2); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", issue_ready); end
    flush = 1'b1; #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_flush_ready: got %b expected 0", issue_ready); end
    @(negedge clk);
    resetn = 1'b1;
    idle();
    step();
  endtask

  task automatic test_basic_issue();
    drive(1, 1, 5'd8, 0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL basic_accept: got %b expected 1", issue_ready); end
    step();
    drive(1, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0); #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", busy1); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL basic_stall: got %b expected 0", issue_ready); end
    total++; if (pending_total !== 7'd1) begin bad++; $display("FAIL basic_total: got %0d expected 1", pending_total); end
    step();
  endtask

  task automatic test_write_through();
    drive(1, 0, 0, 5'd8, 1, 0, 0, 1, 5'd8, 0); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL wt_busy: got %b expected 0", busy1); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL wt_ready: got %b expected 1", issue_ready); end
    step();
    idle(); #1;
    total++; if (pending_total !== 7'd0) begin bad++; $display("FAIL wt_total: got %0d expected 0", pending_total); end
  endtask

  task automatic test_saturation();
    issue_to(5'd5); issue_to(5'd5); issue_to(5'd5);
    drive(1, 1, 5'd5, 0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL sat_full: got %b expected 0", issue_ready); end
    total++; if (pending_total !== 7'd3) begin bad++; $display("FAIL sat_total: got %0d expected 3", pending_total); end
    step();
    drive(1, 1, 5'd5, 0, 0, 0, 0, 1, 5'd5, 0); #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL sat_wb_issue: got %b expected 1", issue_ready); end
    step();
    drive(0, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0); #1;
    total++; if (pending_total !== 7'd3) begin bad++; $display("FAIL sat_hold: got %0d expected 3", pending_total); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sat_busy: got %b expected 1", busy1); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
      step();
    end
    idle(); #1;
    total++; if (pending_total !== 7'd0) begin bad++; $display("FAIL sat_drain: got %0d expected 0", pending_total); end
  endtask

  task automatic test_zero_reg();
    issue_to(5'd2);
    drive(1, 1, 5'd0, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0); #1;
    total++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b%b expected 00", busy1, busy2); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL zero_ready: got %b expected 1", issue_ready); end
    step();
    idle(); #1;
    total++; if (pending_total !== 7'd1) begin bad++; $display("FAIL zero_total: got %0d expected 1", pending_total); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd2, 0);
    step();
  endtask

  task automatic test_flush();
    issue_to(5'd3); issue_to(5'd3); issue_to(5'd9);
    idle(); #1;
    total++; if (pending_total !== 7'd3) begin bad++; $display("FAIL flush_pre: got %0d expected 3", pending_total); end
    drive(1, 1, 5'd4, 0, 0, 0, 0, 0, 0, 1); #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b expected 0", issue_ready); end
    step();
    drive(0, 0, 0, 5'd3, 1, 5'd9, 1, 0, 0, 0); #1;
    total++; if (pending_total !== 7'd0) begin bad++; $display("FAIL flush_total: got %0d expected 0", pending_total); end
    total++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b%b expected 00", busy1, busy2); end
  endtask

  task automatic test_async_reset();
    issue_to(5'd7); issue_to(5'd7);
    drive(0, 0, 0, 5'd7, 1, 0, 0, 0, 0, 0); #1;
    total++; if (busy1 !== 1'b1 || pending_total !== 7'd2) begin bad++; $display("FAIL areset_pre: got busy=%b total=%0d expected busy=1 total=2", busy1, pending_total); end
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b expected 0", busy1); end
    total++; if (pending_total !== 7'd0) begin bad++; $display("FAIL areset_total: got %0d expected 0", pending_total); end
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    @(negedge clk);
    resetn = 1'b1;
    idle();
    step();
  endtask

  task automatic test_random();
    int live [$];
    for (int n = 0; n < 400; n++) begin
      live.delete();
      for (int r = 1; r < 32; r++) if (cnt_m[r] > 0) live.push_back(r);
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), $urandom_range(0, 1),
            0, 0, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1) begin
        wb_valid = 1'b1;
        wb_wa = (live.size() > 0 && $urandom_range(0, 7) != 0)
              ? 5'(live[$urandom_range(0, live.size() - 1)]) : 5'd0;
      end
      #1;
      total++; if (busy1 !== m_busy(issue_ra1)) begin bad++; $display("FAIL rnd_busy1: cycle %0d got %b expected %b", n, busy1, m_busy(issue_ra1)); end
      total++; if (busy2 !== m_busy(issue_ra2)) begin bad++; $display("FAIL rnd_busy2: cycle %0d got %b expected %b", n, busy2, m_busy(issue_ra2)); end
      total++; if (issue_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready: cycle %0d got %b expected %b", n, issue_ready, m_ready()); end
      step();
      exp_q.push_back(7'(m_total()));
      if (exp_q.size() > 0) begin
        logic [6:0] e;
        e = exp_q.pop_front();
        total++; if (pending_total !== e) begin bad++; $display("FAIL rnd_total: cycle %0d got %0d expected %0d", n, pending_total, e); end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_write_through();
    test_saturation();
    test_zero_reg();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
